cell_grid_renderer: RTL

- Reader side of the Game-of-Life cell grid: snapshots the packed cell vector and walks it, emitting one pixel write per cycle on the x/y/colour/plot interface of the 160x120 vga_adapter.
- Each cell is drawn as a CELL_PX x CELL_PX square. An optional cursor border marks the cell currently selected for toggling.
- Sits between the control/datapath pair and vga_adapter, and replaces the per-cell draw path.

---
 rtl/cell_grid_renderer_if.sv | 23 ++
 rtl/cell_grid_renderer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cell_grid_renderer_if.sv
// cell_grid_renderer_if: control and pixel-stream bundle between the renderer, its controller and vga_adapter.
interface cell_grid_renderer_if #(
   parameter int COLS = 8,
   parameter int ROWS = 8
);
   localparam int N  = COLS * ROWS;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   logic          start;
   logic          abort;
   logic [N-1:0]  grid;
   logic          cursor_en;
   logic [IW-1:0] cursor_idx;
   logic          busy;
   logic          done;
   logic [7:0]    x;
   logic [6:0]    y;
   logic [2:0]    colour;
   logic          plot;
   modport master (output start, abort, grid, cursor_en, cursor_idx,
                   input  busy, done, x, y, colour, plot);
   modport slave  (input  start, abort, grid, cursor_en, cursor_idx,
                   output busy, done, x, y, colour, plot);
endinterface

// File: rtl/cell_grid_renderer.sv
// cell_grid_renderer: snapshots the cell grid and streams it as CELL_PX squares, one pixel per cycle.
module cell_grid_renderer #(
   parameter int         COLS          = 8,
   parameter int         ROWS          = 8,
   parameter int         CELL_PX       = 4,
   parameter int         X_ORG         = 0,
   parameter int         Y_ORG         = 0,
   parameter logic [2:0] LIVE_COLOUR   = 3'b100,
   parameter logic [2:0] DEAD_COLOUR   = 3'b000,
   parameter logic [2:0] CURSOR_COLOUR = 3'b010
) (
   input logic                   clk,
   input logic                   resetN,
   cell_grid_renderer_if.slave   bus
);
   localparam int N  = COLS * ROWS;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [1:0] S_IDLE = 2'd0, S_PLOT = 2'd1, S_FIN = 2'd2;

   logic [1:0]    r_state;
   logic [N-1:0]  r_grid;
   logic          r_cen;
   logic [IW-1:0] r_cidx;
   logic [PW-1:0] r_px, r_py;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          r_last, r_busy, r_done, r_plot;
   logic [7:0]    r_x;
   logic [6:0]    r_y;
   logic [2:0]    r_colour;

   // In IDLE the pixel emitted on the accepting edge is built from the live inputs at counter zero.
   logic          w_idle;
   logic [N-1:0]  w_grid;
   logic          w_cen;
   logic [IW-1:0] w_cidx, w_cell;
   logic [PW-1:0] w_px, w_py, w_n_px, w_n_py;
   logic [CW-1:0] w_col, w_n_col;
   logic [RW-1:0] w_row, w_n_row;
   logic          w_px_end, w_col_end, w_py_end, w_row_end, w_end, w_border, w_step;
   logic [7:0]    w_x;
   logic [6:0]    w_y;
   logic [2:0]    w_colour;

   assign w_idle    = r_state == S_IDLE;
   assign w_grid    = w_idle ? bus.grid : r_grid;
   assign w_cen     = w_idle ? bus.cursor_en : r_cen;
   assign w_cidx    = w_idle ? bus.cursor_idx : r_cidx;
   assign w_px      = w_idle ? '0 : r_px;
   assign w_py      = w_idle ? '0 : r_py;
   assign w_col     = w_idle ? '0 : r_col;
   assign w_row     = w_idle ? '0 : r_row;
   assign w_px_end  = w_px == PW'(CELL_PX - 1);
   assign w_py_end  = w_py == PW'(CELL_PX - 1);
   assign w_col_end = w_col == CW'(COLS - 1);
   assign w_row_end = w_row == RW'(ROWS - 1);
   assign w_end     = w_px_end && w_col_end && w_py_end && w_row_end;
   assign w_n_px    = w_px_end ? '0 : w_px + 1'b1;
   assign w_n_col   = !w_px_end ? w_col : w_col_end ? '0 : w_col + 1'b1;
   assign w_n_py    = !(w_px_end && w_col_end) ? w_py : w_py_end ? '0 : w_py + 1'b1;
   assign w_n_row   = !(w_px_end && w_col_end && w_py_end) ? w_row : w_row_end ? '0 : w_row + 1'b1;
   assign w_cell    = IW'(int'(w_row) * COLS + int'(w_col));
   assign w_border  = (w_px == '0) || w_px_end || (w_py == '0) || w_py_end;
   assign w_colour  = (w_cen && w_cell == w_cidx && w_border) ? CURSOR_COLOUR :
                      w_grid[w_cell] ? LIVE_COLOUR : DEAD_COLOUR;
   assign w_x       = 8'(X_ORG + int'(w_col) * CELL_PX + int'(w_px));
   assign w_y       = 7'(Y_ORG + int'(w_row) * CELL_PX + int'(w_py));
   assign w_step    = (w_idle && bus.start) || (r_state == S_PLOT && !bus.abort && !r_last);

   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         r_state  <= S_IDLE;
         r_grid   <= '0;
         r_cen    <= 1'b0;
         r_cidx   <= '0;
         r_px     <= '0;
         r_py     <= '0;
         r_col    <= '0;
         r_row    <= '0;
         r_last   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_plot   <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_step) begin
            r_state  <= S_PLOT;
            r_busy   <= 1'b1;
            r_plot   <= 1'b1;
            r_x      <= w_x;
            r_y      <= w_y;
            r_colour <= w_colour;
            r_px     <= w_n_px;
            r_py     <= w_n_py;
            r_col    <= w_n_col;
            r_row    <= w_n_row;
            r_last   <= w_end;
         end else if (r_state == S_PLOT) begin
            // Abort outranks completion, so an aborted frame never reports done.
            r_state <= bus.abort ? S_IDLE : S_FIN;
            r_done  <= !bus.abort;
            r_busy  <= 1'b0;
            r_plot  <= 1'b0;
         end else begin
            r_state <= S_IDLE;
         end
         if (w_idle && bus.start) begin
            r_grid <= bus.grid;
            r_cen  <= bus.cursor_en;
            r_cidx <= bus.cursor_idx;
         end
      end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.plot   = r_plot;
   assign bus.x      = r_x;
   assign bus.y      = r_y;
   assign bus.colour = r_colour;
endmodule
